// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control
//               sequencer with instruction/data memory handshakes.
//               Define SEQ_TIMEOUT_EN to fault on memory requests that wait
//               TIMEOUT_CYCLES cycles without ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       ir_load,
    output logic       reg_write_en,
    output logic       pc_update,
    output logic       instret,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd6
    } state_t;

    // Only the control behaviour of an opcode matters here, so the eight
    // legal opcodes collapse into four sequencing classes.
    typedef enum logic [1:0] {
        CLS_WB = 2'd0,
        CLS_LW = 2'd1,
        CLS_ST = 2'd2,
        CLS_BR = 2'd3
    } class_t;

    localparam logic [6:0] c_opR     = 7'b0110011;
    localparam logic [6:0] c_opImm   = 7'b0010011;
    localparam logic [6:0] c_opLw    = 7'b0000011;
    localparam logic [6:0] c_opS     = 7'b0100011;
    localparam logic [6:0] c_opB     = 7'b1100011;
    localparam logic [6:0] c_opJal   = 7'b1101111;
    localparam logic [6:0] c_opLui   = 7'b0110111;
    localparam logic [6:0] c_opAuipc = 7'b0010111;

    state_t r_state;
    class_t r_class;
    class_t w_decClass;
    logic   w_decLegal;
    logic   w_retire;
    logic   w_timeout;
    state_t w_afterRetire;

    always_comb begin
        w_decClass = CLS_WB;
        w_decLegal = 1'b1;
        case (opcode)
            c_opR, c_opImm, c_opJal, c_opLui, c_opAuipc: w_decClass = CLS_WB;
            c_opLw:  w_decClass = CLS_LW;
            c_opS:   w_decClass = CLS_ST;
            c_opB:   w_decClass = CLS_BR;
            default: w_decLegal = 1'b0;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int                c_cntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cntW-1:0] c_cntLast = c_cntW'(TIMEOUT_CYCLES - 1);

    logic [c_cntW-1:0] r_waitCnt;
    logic              w_waiting;

    // Counter holds the number of already-elapsed unanswered request cycles,
    // so the TIMEOUT_CYCLES-th request cycle sees c_cntLast.
    assign w_timeout = (r_waitCnt == c_cntLast);
    assign w_waiting = ((r_state == FETCH) && !imem_ready)
                    || ((r_state == MEMORY) && !dmem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= '0;
        end else if (w_waiting && !w_timeout) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end else begin
            r_waitCnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_afterRetire = run ? FETCH : IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_class <= CLS_WB;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        r_state <= DECODE;
                    end else if (w_timeout) begin
                        r_state <= FAULT;
                    end
                end
                DECODE: begin
                    r_class <= w_decClass;
                    r_state <= w_decLegal ? EXECUTE : FAULT;
                end
                EXECUTE: begin
                    case (r_class)
                        CLS_LW, CLS_ST: r_state <= MEMORY;
                        CLS_BR:         r_state <= w_afterRetire;
                        default:        r_state <= WRITEBACK;
                    endcase
                end
                MEMORY: begin
                    if (dmem_ready) begin
                        r_state <= (r_class == CLS_ST) ? w_afterRetire : WRITEBACK;
                    end else if (w_timeout) begin
                        r_state <= FAULT;
                    end
                end
                WRITEBACK: begin
                    r_state <= w_afterRetire;
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= FAULT;
                end
            endcase
        end
    end

    // Strobes decode straight from the state register (plus ready for the
    // Mealy cases) so they are all zero the instant reset asserts.
    assign w_retire = ((r_state == EXECUTE) && (r_class == CLS_BR))
                   || ((r_state == MEMORY) && (r_class == CLS_ST) && dmem_ready)
                   || (r_state == WRITEBACK);

    assign imem_req     = (r_state == FETCH);
    assign ir_load      = (r_state == FETCH) && imem_ready;
    assign dmem_req     = (r_state == MEMORY);
    assign dmem_we      = (r_state == MEMORY) && (r_class == CLS_ST);
    assign reg_write_en = (r_state == WRITEBACK);
    assign pc_update    = w_retire;
    assign instret      = w_retire;
    assign state        = r_state;
    assign busy         = (r_state != IDLE) && (r_state != FAULT);
    assign fault        = (r_state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Self-checking bench for cpu_sequencer; an instruction-level
//               trace model predicts every cycle's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

`ifdef SEQ_TIMEOUT_EN
    localparam int c_timeout = 4;
`else
    localparam int c_timeout = 16;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_load, reg_write_en;
    logic       pc_update, instret, busy, fault;
    logic [2:0] state;

    int nCmp = 0;
    int nBad = 0;
    int cycNo = 0;
    int lat = 0, lastLat = 0, dCnt = 0, lastD = 0, wCnt = 0, lastW = 0;
    logic [2:0] prevSt = 3'd0;

    localparam logic [6:0] c_r = 7'b0110011, c_imm = 7'b0010011, c_lw = 7'b0000011;
    localparam logic [6:0] c_s = 7'b0100011, c_b = 7'b1100011, c_jal = 7'b1101111;
    localparam logic [6:0] c_lui = 7'b0110111, c_auipc = 7'b0010111;

    cpu_sequencer #(.TIMEOUT_CYCLES(c_timeout)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ir_load(ir_load), .reg_write_en(reg_write_en), .pc_update(pc_update),
        .instret(instret), .state(state), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    // Expected output vector: {state, imem_req, dmem_req, dmem_we, ir_load,
    // reg_write_en, pc_update, instret, busy, fault}.
    function automatic logic [11:0] mk(input logic [2:0] st, input bit ireq, dreq, we, irl, rwe, ret);
        bit bsy = (st != 3'd0) && (st != 3'd6);
        return {st, ireq, dreq, we, irl, rwe, ret, ret, bsy, (st == 3'd6)};
    endfunction

    localparam logic [11:0] c_zero = 12'd0;

    // 0 illegal, 1 register-writing, 2 load, 3 store, 4 branch
    function automatic int classify(input logic [6:0] op);
        if (op == c_r || op == c_imm || op == c_jal || op == c_lui || op == c_auipc) return 1;
        if (op == c_lw) return 2;
        if (op == c_s)  return 3;
        if (op == c_b)  return 4;
        return 0;
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, check at the
    // falling edge, then advance to the next rising edge.
    task automatic cyc(input logic rs, rn, input logic [6:0] opc,
                       input logic iR, dR, input logic [11:0] e);
        logic [11:0] act;
        rst = rs; run = rn; opcode = opc; imem_ready = iR; dmem_ready = dR;
        @(negedge clk);
        cycNo++;
        act = {state, imem_req, dmem_req, dmem_we, ir_load, reg_write_en,
               pc_update, instret, busy, fault};
        nCmp++;
        if (act !== e) begin
            nBad++;
            $display("FAIL cycle %0d outputs: got %b want %b", cycNo, act, e);
        end
        if (state == 3'd1 && prevSt != 3'd1) begin
            lat = 1; dCnt = 0; wCnt = 0;
        end else begin
            lat++;
        end
        if (dmem_req) dCnt++;
        if (reg_write_en) wCnt++;
        if (instret) begin
            lastLat = lat; lastD = dCnt; lastW = wCnt;
        end
        prevSt = state;
        @(posedge clk);
        #1;
    endtask

    // One instruction from FETCH entry. stray=1 scrambles the opcode outside
    // DECODE and raises ready inputs whose request is low.
    task automatic doInstr(input logic [6:0] opc, input int fw, input int mw,
                           input logic runEnd, input bit stray);
        int cls = classify(opc);
        logic [6:0] junk = stray ? 7'h7f : opc;
        bit isS = (cls == 3);
        for (int i = 0; i < fw; i++) cyc(0, runEnd, junk, 0, stray, mk(1, 1, 0, 0, 0, 0, 0));
        cyc(0, runEnd, junk, 1, stray, mk(1, 1, 0, 0, 1, 0, 0));
        cyc(0, runEnd, opc, stray, stray, mk(2, 0, 0, 0, 0, 0, 0));
        if (cls == 0) begin
            for (int i = 0; i < 3; i++) cyc(0, 1, c_r, 1, 1, mk(6, 0, 0, 0, 0, 0, 0));
            return;
        end
        cyc(0, runEnd, junk, stray, stray, mk(3, 0, 0, 0, 0, 0, cls == 4));
        if (cls == 4) return;
        if (cls == 2 || cls == 3) begin
            for (int i = 0; i < mw; i++) cyc(0, runEnd, junk, stray, 0, mk(4, 0, 1, isS, 0, 0, 0));
            cyc(0, runEnd, junk, stray, 1, mk(4, 0, 1, isS, 0, 0, isS));
            if (isS) return;
        end
        cyc(0, runEnd, junk, stray, stray, mk(5, 0, 0, 0, 0, 1, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(1, 1, c_r, 1, 1, c_zero);
        cyc(1, 1, c_r, 1, 1, c_zero);
        cyc(0, 0, c_r, 1, 1, c_zero);
        cyc(0, 1, c_r, 1, 1, c_zero);

        doInstr(c_r, 0, 0, 1, 0);
        lit("R latency", lastLat, 4);
        doInstr(c_lw, 2, 3, 1, 1);
        lit("LW waited latency", lastLat, 10);
        lit("LW dmem_req cycles", lastD, 4);
        doInstr(c_b, 0, 0, 0, 1);
        lit("B latency", lastLat, 3);
        cyc(0, 0, c_r, 1, 1, c_zero);
        cyc(0, 1, c_r, 0, 0, c_zero);
        doInstr(c_s, 0, 0, 1, 1);
        lit("S latency", lastLat, 4);
        lit("S reg_write_en count", lastW, 0);
        doInstr(c_imm, 1, 0, 1, 1);
        doInstr(c_lui, 0, 0, 1, 0);
        doInstr(c_auipc, 2, 0, 1, 1);
        doInstr(c_jal, 0, 0, 1, 1);
        doInstr(c_lw, 0, 0, 1, 0);
        lit("LW zero-wait latency", lastLat, 5);
        doInstr(c_s, 1, 2, 0, 0);
        lit("S waited latency", lastLat, 7);
        cyc(0, 0, c_r, 0, 0, c_zero);

        // Illegal opcode, then reset out of FAULT
        cyc(0, 1, c_r, 0, 0, c_zero);
        doInstr(7'b1111111, 0, 0, 1, 0);
        cyc(1, 1, c_r, 1, 1, c_zero);
        cyc(0, 0, c_r, 1, 1, c_zero);
        cyc(0, 1, c_r, 0, 0, c_zero);
        doInstr(7'b0000000, 1, 0, 1, 0);
        cyc(1, 0, c_r, 0, 0, c_zero);

        // Reset while a load waits in MEMORY
        cyc(0, 1, c_r, 0, 0, c_zero);
        cyc(0, 1, c_lw, 1, 0, mk(1, 1, 0, 0, 1, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(2, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(3, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(4, 0, 1, 0, 0, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(4, 0, 1, 0, 0, 0, 0));
        cyc(1, 1, c_lw, 1, 1, c_zero);
        cyc(1, 1, c_lw, 1, 1, c_zero);
        cyc(0, 0, c_lw, 1, 1, c_zero);
        cyc(0, 1, c_lw, 0, 0, c_zero);
        doInstr(c_r, 0, 0, 0, 0);
        lit("R after reset latency", lastLat, 4);
        cyc(0, 0, c_r, 0, 0, c_zero);

`ifdef SEQ_TIMEOUT_EN
        cyc(0, 1, c_r, 0, 0, c_zero);
        for (int i = 0; i < 4; i++) cyc(0, 1, c_r, 0, 0, mk(1, 1, 0, 0, 0, 0, 0));
        cyc(0, 1, c_r, 1, 1, mk(6, 0, 0, 0, 0, 0, 0));
        cyc(1, 0, c_r, 0, 0, c_zero);
        cyc(0, 1, c_r, 0, 0, c_zero);
        doInstr(c_r, 3, 0, 1, 0);
        lit("R ready on last allowed cycle latency", lastLat, 7);
        doInstr(c_lw, 0, 3, 1, 0);
        cyc(0, 1, c_lw, 1, 0, mk(1, 1, 0, 0, 1, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(2, 0, 0, 0, 0, 0, 0));
        cyc(0, 1, c_lw, 0, 0, mk(3, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) cyc(0, 1, c_lw, 0, 0, mk(4, 0, 1, 0, 0, 0, 0));
        cyc(0, 1, c_lw, 1, 1, mk(6, 0, 0, 0, 0, 0, 0));
        cyc(1, 0, c_r, 0, 0, c_zero);
`else
        cyc(0, 1, c_r, 0, 0, c_zero);
        doInstr(c_r, 20, 0, 1, 1);
        lit("R long fetch wait latency", lastLat, 24);
        doInstr(c_lw, 0, 20, 0, 0);
        lit("LW long memory wait latency", lastLat, 25);
        cyc(0, 0, c_r, 0, 0, c_zero);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
`default_nettype wire
